// File: rtl/cc_cond_unit_pkg.sv
// Shared definitions for the Y86-64 condition-code unit: ALU/cond codes, CC bit
// positions and the CC-update FSM states.
package cc_cond_unit_pkg;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_XOR = 4'd3;

  localparam logic [3:0] C_ALWAYS = 4'd0;
  localparam logic [3:0] C_LE     = 4'd1;
  localparam logic [3:0] C_L      = 4'd2;
  localparam logic [3:0] C_E      = 4'd3;
  localparam logic [3:0] C_NE     = 4'd4;
  localparam logic [3:0] C_GE     = 4'd5;
  localparam logic [3:0] C_G      = 4'd6;

  localparam int CC_ZF = 2;
  localparam int CC_SF = 1;
  localparam int CC_OF = 0;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_PENDING = 1'b1
  } state_t;

endpackage

// File: rtl/cc_cond_unit_cond_eval.sv
// Combinational Y86 jXX/cmovXX condition evaluator: maps {ZF,SF,OF} and the
// instruction ifun to the branch/move decision. Shared with Decode/PC-select.
module cond_eval
  import cc_cond_unit_pkg::*;
(
  input  logic [2:0] i_cc,
  input  logic [3:0] i_cond_fun,
  output logic       o_cnd
);

  logic w_zf;
  logic w_lt;

  assign w_zf = i_cc[CC_ZF];
  // signed "less than" after a compare is SF xor OF
  assign w_lt = i_cc[CC_SF] ^ i_cc[CC_OF];

  always_comb begin
    o_cnd = 1'b0;
    case (i_cond_fun)
      C_ALWAYS: o_cnd = 1'b1;
      C_LE:     o_cnd = w_lt | w_zf;
      C_L:      o_cnd = w_lt;
      C_E:      o_cnd = w_zf;
      C_NE:     o_cnd = ~w_zf;
      C_GE:     o_cnd = ~w_lt;
      C_G:      o_cnd = ~w_lt & ~w_zf;
      default:  o_cnd = 1'b0;
    endcase
  end

endmodule

// File: rtl/cc_cond_unit.sv
// Y86-64 Execute-stage condition-code register and condition query unit.
// Define CC_CHECK_EN to build the ALU result cross-checker (alu_mismatch).
module cc_cond_unit
  import cc_cond_unit_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    alu_valid,
  output logic                    alu_ready,
  input  logic [3:0]              alu_fun,
  input  logic signed [WIDTH-1:0] alu_a,
  input  logic signed [WIDTH-1:0] alu_b,
  input  logic signed [WIDTH-1:0] alu_out,
  input  logic                    set_cc,
  input  logic                    cond_req,
  output logic                    cond_ready,
  input  logic [3:0]              cond_fun,
  output logic                    cond_valid,
  output logic                    cnd,
  output logic [2:0]              cc_out,
  output logic                    alu_mismatch
);

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [3:0]              r_fun;
  logic signed [WIDTH-1:0] r_a;
  logic signed [WIDTH-1:0] r_b;
  logic signed [WIDTH-1:0] r_out;
  logic [2:0]              r_cc;
  logic                    r_cond_valid;
  logic                    r_cnd;
  logic                    w_cnd;
  logic                    w_stage;
  logic                    w_cond_xfer;

  function automatic logic [2:0] calc_flags(
    input logic [3:0]              fun,
    input logic signed [WIDTH-1:0] a,
    input logic signed [WIDTH-1:0] b,
    input logic signed [WIDTH-1:0] out
  );
    logic a_s;
    logic b_s;
    logic o_s;
    logic of;
    a_s = a[WIDTH-1];
    b_s = b[WIDTH-1];
    o_s = out[WIDTH-1];
    case (fun)
      ALU_ADD: of = (a_s == b_s) && (o_s != a_s);
      // sub computes b - a, so overflow is judged against b's sign
      ALU_SUB: of = (a_s != b_s) && (o_s != b_s);
      default: of = 1'b0;
    endcase
    calc_flags = {(out == '0), o_s, of};
  endfunction

  assign alu_ready   = (r_state == ST_IDLE);
  assign cond_ready  = (r_state == ST_IDLE) & ~(alu_valid & set_cc);
  assign w_stage     = alu_valid & alu_ready & set_cc;
  assign w_cond_xfer = cond_req & cond_ready;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:    if (w_stage) w_state_nxt = ST_PENDING;
      ST_PENDING: w_state_nxt = ST_IDLE;
      default:    w_state_nxt = ST_IDLE;
    endcase
  end

  cond_eval u_cond_eval (
    .i_cc       (r_cc),
    .i_cond_fun (cond_fun),
    .o_cnd      (w_cnd)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_fun        <= '0;
      r_a          <= '0;
      r_b          <= '0;
      r_out        <= '0;
      r_cc         <= 3'b100;
      r_cond_valid <= 1'b0;
      r_cnd        <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_stage) begin
        r_fun <= alu_fun;
        r_a   <= alu_a;
        r_b   <= alu_b;
        r_out <= alu_out;
      end
      if (r_state == ST_PENDING) r_cc <= calc_flags(r_fun, r_a, r_b, r_out);
      // queries only land in IDLE, so w_cnd sees the CC value settled at this edge
      r_cond_valid <= w_cond_xfer;
      if (w_cond_xfer) r_cnd <= w_cnd;
    end
  end

  assign cc_out     = r_cc;
  assign cond_valid = r_cond_valid;
  assign cnd        = r_cnd;

`ifdef CC_CHECK_EN
  logic r_mismatch;

  function automatic logic signed [WIDTH-1:0] ref_result(
    input logic [3:0]              fun,
    input logic signed [WIDTH-1:0] a,
    input logic signed [WIDTH-1:0] b,
    input logic signed [WIDTH-1:0] out
  );
    case (fun)
      ALU_ADD: ref_result = a + b;
      ALU_SUB: ref_result = b - a;
      ALU_AND: ref_result = a & b;
      ALU_XOR: ref_result = a ^ b;
      default: ref_result = out;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mismatch <= 1'b0;
    end else if ((r_state == ST_PENDING) &&
                 (ref_result(r_fun, r_a, r_b, r_out) != r_out)) begin
      r_mismatch <= 1'b1;
    end
  end

  assign alu_mismatch = r_mismatch;
`else
  assign alu_mismatch = 1'b0;
`endif

endmodule

// File: tb/tb_cc_cond_unit.sv
// Self-checking bench for cc_cond_unit: directed vector table, multi-cycle
// corner sequences and randomized traffic against a reference model.
module tb_cc_cond_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        alu_valid;
  logic        alu_ready;
  logic [3:0]  alu_fun;
  logic [63:0] alu_a;
  logic [63:0] alu_b;
  logic [63:0] alu_out;
  logic        set_cc;
  logic        cond_req;
  logic        cond_ready;
  logic [3:0]  cond_fun;
  logic        cond_valid;
  logic        cnd;
  logic [2:0]  cc_out;
  logic        alu_mismatch;

  int errors = 0;
  int checks = 0;
  logic [2:0] cc_model;

`ifdef CC_CHECK_EN
  localparam logic EXP_MM = 1'b1;
`else
  localparam logic EXP_MM = 1'b0;
`endif

  localparam logic signed [64:0] MAXV = 65'sh0_7FFF_FFFF_FFFF_FFFF;
  localparam logic signed [64:0] MINV = -MAXV - 65'sd1;

  cc_cond_unit #(.WIDTH(64)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .alu_valid    (alu_valid),
    .alu_ready    (alu_ready),
    .alu_fun      (alu_fun),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_out      (alu_out),
    .set_cc       (set_cc),
    .cond_req     (cond_req),
    .cond_ready   (cond_ready),
    .cond_fun     (cond_fun),
    .cond_valid   (cond_valid),
    .cnd          (cnd),
    .cc_out       (cc_out),
    .alu_mismatch (alu_mismatch)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Flags from true two's-complement arithmetic: overflow means the exact
  // result falls outside the signed 64-bit range.
  function automatic logic [2:0] model_cc(input logic [3:0] fun, input logic [63:0] a,
                                          input logic [63:0] b, input logic [63:0] out);
    logic signed [64:0] wide;
    logic of;
    of = 1'b0;
    if (fun == 4'd0) begin
      wide = $signed({a[63], a}) + $signed({b[63], b});
      of = (wide > MAXV) || (wide < MINV);
    end else if (fun == 4'd1) begin
      wide = $signed({b[63], b}) - $signed({a[63], a});
      of = (wide > MAXV) || (wide < MINV);
    end
    return {(out == 64'd0), ($signed(out) < 0), of};
  endfunction

  function automatic logic model_cnd(input logic [3:0] f, input logic [2:0] cc);
    logic zf, lt;
    zf = cc[2];
    lt = cc[1] != cc[0];
    case (f)
      4'd0: return 1'b1;
      4'd1: return lt || zf;
      4'd2: return lt;
      4'd3: return zf;
      4'd4: return !zf;
      4'd5: return !lt;
      4'd6: return !lt && !zf;
      default: return 1'b0;
    endcase
  endfunction

  task automatic alu_update(input logic [3:0] fun, input logic [63:0] a, input logic [63:0] b,
                            input logic [63:0] out, input logic sc);
    @(negedge clk);
    alu_valid = 1'b1; alu_fun = fun; alu_a = a; alu_b = b; alu_out = out; set_cc = sc;
    #1;
    chk("xfer_alu_ready", 64'(alu_ready), 64'd1);
    chk("xfer_cond_ready", 64'(cond_ready), 64'(!sc));
    @(posedge clk); #1;
    alu_valid = 1'b0; set_cc = 1'b0;
    if (sc) begin
      chk("pend_alu_ready", 64'(alu_ready), 64'd0);
      chk("pend_cc_hold", 64'(cc_out), 64'(cc_model));
      cc_model = model_cc(fun, a, b, out);
      @(posedge clk); #1;
    end
    chk("cc_after_update", 64'(cc_out), 64'(cc_model));
    chk("idle_alu_ready", 64'(alu_ready), 64'd1);
  endtask

  task automatic query(input logic [3:0] f);
    @(negedge clk);
    cond_req = 1'b1; cond_fun = f;
    #1;
    chk("q_cond_ready", 64'(cond_ready), 64'd1);
    @(posedge clk); #1;
    cond_req = 1'b0;
    chk("q_valid", 64'(cond_valid), 64'd1);
    chk("q_cnd", 64'(cnd), 64'(model_cnd(f, cc_model)));
  endtask

  typedef struct {
    logic [3:0]  fun;
    logic [63:0] a, b, out;
    logic        sc;
    logic [3:0]  qf;
    logic [2:0]  exp_cc;
    logic        exp_cnd;
  } vec_t;

  vec_t tbl[9];

  initial begin
    rst_n = 1'b1; alu_valid = 1'b0; alu_fun = '0; alu_a = '0; alu_b = '0; alu_out = '0;
    set_cc = 1'b0; cond_req = 1'b0; cond_fun = '0;
    cc_model = 3'b100;

    tbl[0] = '{4'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 64'h8000_0000_0000_0000, 1'b1, 4'd1, 3'b011, 1'b0};
    tbl[1] = '{4'd1, 64'd0, 64'd0, 64'd0, 1'b0, 4'd6, 3'b011, 1'b1};
    tbl[2] = '{4'd1, 64'd5, 64'd5, 64'd0, 1'b1, 4'd3, 3'b100, 1'b1};
    tbl[3] = '{4'd1, 64'd0, 64'd0, 64'd0, 1'b0, 4'd4, 3'b100, 1'b0};
    tbl[4] = '{4'd1, 64'd3, 64'd1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 4'd2, 3'b010, 1'b1};
    tbl[5] = '{4'd1, 64'd1, 64'h8000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 4'd5, 3'b001, 1'b0};
    tbl[6] = '{4'd7, 64'd0, 64'd0, 64'h8000_0000_0000_0000, 1'b1, 4'd9, 3'b010, 1'b0};
    tbl[7] = '{4'd2, 64'hFF, 64'd1, 64'd1, 1'b1, 4'd6, 3'b000, 1'b1};
    tbl[8] = '{4'd3, 64'hF0, 64'hF0, 64'd0, 1'b1, 4'd0, 3'b100, 1'b1};

    // Reset state
    #3 rst_n = 1'b0;
    #1;
    chk("rst_cc", 64'(cc_out), 64'h4);
    chk("rst_cond_valid", 64'(cond_valid), 64'd0);
    chk("rst_cnd", 64'(cnd), 64'd0);
    chk("rst_mismatch", 64'(alu_mismatch), 64'd0);
    chk("rst_alu_ready", 64'(alu_ready), 64'd1);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    query(4'd3);
    @(posedge clk); #1;
    chk("valid_pulse_len", 64'(cond_valid), 64'd0);

    // Directed table
    for (int i = 0; i < 9; i++) begin
      alu_update(tbl[i].fun, tbl[i].a, tbl[i].b, tbl[i].out, tbl[i].sc);
      chk($sformatf("tbl%0d_cc", i), 64'(cc_out), 64'(tbl[i].exp_cc));
      query(tbl[i].qf);
      chk($sformatf("tbl%0d_cnd", i), 64'(cnd), 64'(tbl[i].exp_cnd));
    end

    // Back-to-back queries on consecutive edges
    @(negedge clk);
    cond_req = 1'b1; cond_fun = 4'd3;
    @(posedge clk); #1;
    chk("b2b_valid0", 64'(cond_valid), 64'd1);
    chk("b2b_cnd0", 64'(cnd), 64'd1);
    @(negedge clk) cond_fun = 4'd4;
    @(posedge clk); #1;
    cond_req = 1'b0;
    chk("b2b_valid1", 64'(cond_valid), 64'd1);
    chk("b2b_cnd1", 64'(cnd), 64'd0);
    @(posedge clk); #1;
    chk("b2b_valid_end", 64'(cond_valid), 64'd0);

    // Same-cycle ALU update and query: update wins, query waits out PENDING
    @(negedge clk);
    alu_valid = 1'b1; set_cc = 1'b1; alu_fun = 4'd2; alu_a = 64'hF0; alu_b = 64'hF0; alu_out = 64'hF0;
    cond_req = 1'b1; cond_fun = 4'd3;
    #1 chk("ord_ready_xfer", 64'(cond_ready), 64'd0);
    @(posedge clk); #1;
    alu_valid = 1'b0; set_cc = 1'b0;
    chk("ord_ready_pend", 64'(cond_ready), 64'd0);
    chk("ord_no_valid", 64'(cond_valid), 64'd0);
    @(posedge clk); #1;
    cc_model = 3'b000;
    chk("ord_cc", 64'(cc_out), 64'h0);
    chk("ord_no_valid2", 64'(cond_valid), 64'd0);
    @(posedge clk); #1;
    cond_req = 1'b0;
    chk("ord_valid", 64'(cond_valid), 64'd1);
    chk("ord_cnd", 64'(cnd), 64'd0);

    // Reset drops an in-flight cond response
    @(negedge clk);
    cond_req = 1'b1; cond_fun = 4'd0;
    @(posedge clk); #1;
    cond_req = 1'b0;
    chk("inflight_valid", 64'(cond_valid), 64'd1);
    rst_n = 1'b0;
    #1 chk("rst_drop_valid", 64'(cond_valid), 64'd0);
    @(negedge clk) rst_n = 1'b1;
    cc_model = 3'b100;

    // Reset during PENDING discards the staged update
    alu_update(4'd1, 64'd3, 64'd1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1);
    @(negedge clk);
    alu_valid = 1'b1; set_cc = 1'b1; alu_fun = 4'd0; alu_a = 64'd1; alu_b = 64'd2; alu_out = 64'd3;
    @(posedge clk); #1;
    alu_valid = 1'b0; set_cc = 1'b0;
    chk("mid_pend", 64'(alu_ready), 64'd0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_cc", 64'(cc_out), 64'h4);
    chk("mid_rst_ready", 64'(alu_ready), 64'd1);
    @(posedge clk); #1;
    chk("mid_rst_novalid", 64'(cond_valid), 64'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_discard", 64'(cc_out), 64'h4);
    cc_model = 3'b100;

    // Randomized traffic
    for (int i = 0; i < 150; i++) begin
      logic [3:0]  f;
      logic [63:0] a, b, o;
      logic        sc;
      int          sel;
      f = 4'($urandom_range(0, 5));
      if (f >= 4'd4) f = 4'($urandom_range(4, 15));
      sel = int'($urandom_range(0, 3));
      a = {$urandom(), $urandom()};
      b = {$urandom(), $urandom()};
      if (sel == 0) b = a;
      if (sel == 1) begin a = 64'h7FFF_FFFF_FFFF_FFFF; b = 64'($urandom_range(0, 2)); end
      if (sel == 2) begin a[63] = b[63]; end
      case (f)
        4'd0: o = a + b;
        4'd1: o = b - a;
        4'd2: o = a & b;
        4'd3: o = a ^ b;
        default: o = ($urandom_range(0, 1) == 0) ? 64'd0 : {$urandom(), $urandom()};
      endcase
      sc = ($urandom_range(0, 3) != 0);
      alu_update(f, a, b, o, sc);
      query(4'($urandom_range(0, 15)));
    end
    chk("rand_no_mismatch", 64'(alu_mismatch), 64'd0);

    // Result checker: xor 3^5 = 6 but ALU reports 7
    alu_update(4'd3, 64'd3, 64'd5, 64'd7, 1'b1);
    chk("mm_set", 64'(alu_mismatch), 64'(EXP_MM));
    alu_update(4'd0, 64'd1, 64'd1, 64'd2, 1'b1);
    chk("mm_sticky", 64'(alu_mismatch), 64'(EXP_MM));
    @(negedge clk) rst_n = 1'b0;
    #1 chk("mm_clear", 64'(alu_mismatch), 64'd0);
    @(negedge clk) rst_n = 1'b1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
